// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP camera emulator: PCLK/VSYNC/HREF plus RGB565 test patterns, high byte first.
// Optional DVP_TX_FRAME_CNT_EN adds a frame counter stamped into pixel (0,0) and toggling the checker.
module dvp_pattern_tx #(
  parameter int unsigned H_ACTIVE      = 320,
  parameter int unsigned V_ACTIVE      = 240,
  parameter int unsigned H_BLANK       = 32,
  parameter int unsigned V_SYNC_LINES  = 3,
  parameter int unsigned V_BACK_LINES  = 17,
  parameter int unsigned V_FRONT_LINES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        frame_done
`ifdef DVP_TX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned ACT_BYTES  = 2 * H_ACTIVE;
  localparam int unsigned LINE_BYTES = ACT_BYTES + H_BLANK;
  localparam int unsigned BAR_PIX    = H_ACTIVE / 8;
  localparam int unsigned MAX_A      = (V_SYNC_LINES > V_BACK_LINES) ? V_SYNC_LINES : V_BACK_LINES;
  localparam int unsigned MAX_B      = (V_ACTIVE > V_FRONT_LINES) ? V_ACTIVE : V_FRONT_LINES;
  localparam int unsigned MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned BYTE_W     = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int unsigned LINE_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam int unsigned BAR_W      = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t              state, state_nx;
  logic [BYTE_W-1:0]   byte_cnt, byte_nx;
  logic [LINE_W-1:0]   line_cnt, line_nx;
  logic [BAR_W-1:0]    bar_cnt, bar_cnt_nx;
  logic [2:0]          bar_idx, bar_idx_nx;
  logic [1:0]          mode_q, mode_nx;
  logic [15:0]         solid_q, solid_nx;
  logic                vsync_nx, href_nx, busy_nx, frame_done_nx;
  logic [7:0]          data_nx;
  logic [15:0]         pix;
  logic                last_byte, last_line, chk;
  int unsigned         lines_in_state;

  // Next-state, counters and the byte to present during the next byte-time
  always_comb begin
    state_nx       = state;
    byte_nx        = byte_cnt;
    line_nx        = line_cnt;
    bar_cnt_nx     = bar_cnt;
    bar_idx_nx     = bar_idx;
    mode_nx        = mode_q;
    solid_nx       = solid_q;
    vsync_nx       = vsync_out;
    href_nx        = href_out;
    data_nx        = data_out;
    busy_nx        = busy;
    frame_done_nx  = 1'b0;
    pix            = 16'h0000;
    chk            = 1'b0;
    lines_in_state = 1;

    case (state)
      S_VSYNC:  lines_in_state = V_SYNC_LINES;
      S_VBACK:  lines_in_state = V_BACK_LINES;
      S_ACTIVE: lines_in_state = V_ACTIVE;
      S_VFRONT: lines_in_state = V_FRONT_LINES;
      default:  lines_in_state = 1;
    endcase
    last_byte = (byte_cnt == BYTE_W'(LINE_BYTES - 1));
    last_line = (32'(line_cnt) == lines_in_state - 1);

    // pclk_out high now means this edge drives it low: a byte tick
    if (pclk_out) begin
      if (state == S_IDLE) begin
        if (en) begin
          state_nx = S_VSYNC;
          mode_nx  = mode;
          solid_nx = solid_rgb;
        end
      end else begin
        byte_nx = last_byte ? '0 : byte_cnt + BYTE_W'(1);
        if (last_byte) begin
          line_nx = last_line ? '0 : line_cnt + LINE_W'(1);
          if (last_line) begin
            case (state)
              S_VSYNC:  state_nx = S_VBACK;
              S_VBACK:  state_nx = S_ACTIVE;
              S_ACTIVE: state_nx = S_VFRONT;
              S_VFRONT: begin
                frame_done_nx = 1'b1;
                if (en) begin
                  state_nx = S_VSYNC;
                  mode_nx  = mode;
                  solid_nx = solid_rgb;
                end else begin
                  state_nx = S_IDLE;
                end
              end
              default:  state_nx = S_IDLE;
            endcase
          end
        end
      end

      // Colour-bar position tracked incrementally per pixel
      if (byte_nx == '0) begin
        bar_cnt_nx = '0;
        bar_idx_nx = 3'd0;
      end else if (!byte_nx[0] && (32'(byte_nx) < ACT_BYTES)) begin
        if (bar_cnt == BAR_W'(BAR_PIX - 1)) begin
          bar_cnt_nx = '0;
          bar_idx_nx = bar_idx + 3'd1;
        end else begin
          bar_cnt_nx = bar_cnt + BAR_W'(1);
        end
      end

      chk = (|(byte_nx & BYTE_W'(16))) ^ (|(line_nx & LINE_W'(8)));
`ifdef DVP_TX_FRAME_CNT_EN
      chk = chk ^ frame_cnt[0];
`endif
      case (mode_nx)
        2'd0: begin
          case (bar_idx_nx)
            3'd0:    pix = 16'hFFFF;
            3'd1:    pix = 16'hFFE0;
            3'd2:    pix = 16'h07FF;
            3'd3:    pix = 16'h07E0;
            3'd4:    pix = 16'hF81F;
            3'd5:    pix = 16'hF800;
            3'd6:    pix = 16'h001F;
            default: pix = 16'h0000;
          endcase
        end
        2'd1:    pix = 16'(byte_nx >> 1);
        2'd2:    pix = solid_nx;
        default: pix = chk ? 16'hFFFF : 16'h0000;
      endcase
`ifdef DVP_TX_FRAME_CNT_EN
      if ((32'(byte_nx) < 2) && (line_nx == '0)) pix = frame_cnt;
`endif

      vsync_nx = (state_nx == S_VSYNC);
      href_nx  = (state_nx == S_ACTIVE) && (32'(byte_nx) < ACT_BYTES);
      data_nx  = href_nx ? (byte_nx[0] ? pix[7:0] : pix[15:8]) : 8'h00;
      busy_nx  = (state_nx != S_IDLE);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      bar_cnt    <= '0;
      bar_idx    <= 3'd0;
      mode_q     <= 2'd0;
      solid_q    <= 16'h0000;
      pclk_out   <= 1'b0;
      vsync_out  <= 1'b0;
      href_out   <= 1'b0;
      data_out   <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef DVP_TX_FRAME_CNT_EN
      frame_cnt  <= 16'h0000;
`endif
    end else begin
      state      <= state_nx;
      byte_cnt   <= byte_nx;
      line_cnt   <= line_nx;
      bar_cnt    <= bar_cnt_nx;
      bar_idx    <= bar_idx_nx;
      mode_q     <= mode_nx;
      solid_q    <= solid_nx;
      pclk_out   <= ~pclk_out;
      vsync_out  <= vsync_nx;
      href_out   <= href_nx;
      data_out   <= data_nx;
      busy       <= busy_nx;
      frame_done <= frame_done_nx;
`ifdef DVP_TX_FRAME_CNT_EN
      if (frame_done_nx) frame_cnt <= frame_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: doc/dvp_pattern_tx.md
Name: dvp_pattern_tx

Overview:
- OV7670-style DVP transmitter (camera emulator): generates PCLK, VSYNC, HREF and 8-bit data carrying RGB565 test patterns, high byte first.
- Drives camera_read and the SDRAM write path in simulation and in board bring-up without a sensor; its outputs replace PCLK_cam, VSYNC_cam, HREF_cam and data_cam.
- All outputs are registers in the single clk domain.

Parameters:
H_ACTIVE, 320, active pixels per line; must be divisible by 8
V_ACTIVE, 240, active lines per frame
H_BLANK, 32, byte-times with HREF low after each line's active bytes
V_SYNC_LINES, 3, line-times with VSYNC high
V_BACK_LINES, 17, blank line-times after VSYNC
V_FRONT_LINES, 10, blank line-times after the active lines

Ports:
clk  in  1  system clock; pclk_out runs at clk/2
rst_n  in  1  asynchronous active-low reset
en  in  1  level; frames start while high
mode  in  2  pattern select: 0 colour bars, 1 ramp, 2 solid, 3 checker
solid_rgb  in  16  RGB565 colour used by mode 2
pclk_out  out  1  emulated PCLK
vsync_out  out  1  active-high VSYNC
href_out  out  1  active-high HREF
data_out  out  8  DVP byte
busy  out  1  high whenever state is not IDLE
frame_done  out  1  one-clk pulse at the end of each frame

Behaviour:
- Reset: every output is 0, state is IDLE, all counters are 0.
- Reset mid-frame aborts immediately to these values.
- pclk_out toggles every clk from the first clk after reset, in every state.
- Byte tick = a clk edge on which pclk_out goes 1->0.
- vsync_out, href_out and data_out change only on byte ticks, so they are stable while pclk_out rises.
- Line-time = 2*H_ACTIVE + H_BLANK byte-times.
- Counters: byte_cnt counts within the line; line_cnt counts within the state.
- States:
  - IDLE: at a byte tick with en=1, latch mode and solid_rgb, then go to VSYNC.
  - VSYNC: vsync_out=1 for V_SYNC_LINES line-times, then VBACK.
  - VBACK: all outputs low for V_BACK_LINES line-times, then ACTIVE.
  - ACTIVE: V_ACTIVE lines.
    - Each line: href_out=1 for 2*H_ACTIVE byte-times, then 0 for H_BLANK byte-times.
    - Pixel x=0..H_ACTIVE-1, line y=0..V_ACTIVE-1.
    - Byte 2x = pixel[15:8]; byte 2x+1 = pixel[7:0].
    - data_out=0 whenever href_out=0.
  - VFRONT: V_FRONT_LINES line-times with all outputs low. At the last byte tick:
    - pulse frame_done for 1 clk;
    - if en=1, latch mode and solid_rgb again and go directly to VSYNC (back-to-back frames);
    - otherwise go to IDLE.
- If en drops mid-frame, the current frame completes. en is sampled only in IDLE and at the end of VFRONT.
- Changes to mode or solid_rgb mid-frame have no effect until the next latch.
- Patterns:
  - mode 0: 8 equal bars of width H_ACTIVE/8, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The bar index comes from a sub-counter, not a divider.
  - mode 1: pixel = x zero-extended to 16 bits; x wraps modulo 2^16.
  - mode 2: pixel = latched solid_rgb.
  - mode 3: pixel = (x[3]^y[3]) ? FFFF : 0000.
- Counter widths: ceil(log2) of the largest count, minimum 1 bit.

Optional Feature:
DVP_TX_FRAME_CNT_EN
- Defined:
  - Adds output port frame_cnt [15:0]. It resets to 0 and increments on each frame_done, wrapping at FFFF->0000.
  - Pixel (0,0) of each frame carries the frame_cnt value, in place of the pattern value, at the moment ACTIVE is entered.
  - mode 3 uses (x[3]^y[3]^frame_cnt[0]), so the checker inverts every frame.
- Undefined: no frame_cnt port; pixel (0,0) follows the pattern; the checker is static.

Test Plan:
- Reset, then hold for 5 clk -> all outputs 0; pclk_out toggles 0,1,0,1 from the first clk.
- H_ACTIVE=16, V_ACTIVE=4, H_BLANK=4, sync/back/front = 1/1/1, en=1 -> vsync high for exactly 36 byte-times, href high for 32 bytes per line, 4 href pulses, then frame_done after 7 line-times total.
- mode 0 with H_ACTIVE=16 -> line bytes are FF,FF,FF,FF,FF,E0,FF,E0,07,FF,…, ending 00,00,00,00; identical on every line.
- mode 1 -> line bytes 00,00,00,01,00,02,…,00,0F. mode 2 with solid_rgb=1234 -> 12,34 repeated. mode 3 with H_ACTIVE=16 -> first 8 pixels FFFF-free (0000), next 8 FFFF on y=0..3.
- en held high for 2 frames, dropped mid-frame 2 -> frame 2 completes with frame_done, then busy=0 and no further vsync. Asserting rst_n=0 mid-ACTIVE -> all outputs 0 on the same edge.
- With DVP_TX_FRAME_CNT_EN -> frame k's first two bytes equal frame_cnt (00,00 then 00,01); frame_cnt wraps from FFFF to 0000 when forced.
